// File: rtl/bcd_disp_pkg.sv
// Shared types and active-low segment constants for the 3-digit BCD scanning display.
// Segment bit order is {g,f,e,d,c,b,a}; a 0 lights the segment.
package bcd_disp_pkg;

  typedef enum logic [1:0] {
    IDX_ONES     = 2'd0,
    IDX_TENS     = 2'd1,
    IDX_HUNDREDS = 2'd2
  } digit_idx_e;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  localparam logic [2:0] AN_OFF = 3'b111;

  // Active-low one-hot anode enable for a digit position.
  function automatic logic [2:0] an_code(input digit_idx_e d);
    case (d)
      IDX_ONES:     an_code = 3'b110;
      IDX_TENS:     an_code = 3'b101;
      IDX_HUNDREDS: an_code = 3'b011;
      default:      an_code = AN_OFF;
    endcase
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD to active-low 7-segment decoder; codes 10-15 show a dash.
module seg7_decode
  import bcd_disp_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (code)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_7seg_scan.sv
// Three-digit multiplexed 7-segment driver with shadow capture and anti-ghost blanking.
// Optional build macro LEADING_ZERO_BLANK_EN suppresses leading zeros on TENS/HUNDREDS.
module bcd_7seg_scan
  import bcd_disp_pkg::*;
#(
  parameter int REFRESH_DIV = 50000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       LOAD,
  input  logic [3:0] HUNDREDS,
  input  logic [3:0] TENS,
  input  logic [3:0] ONES,
  output logic [6:0] SEG,
  output logic [2:0] AN,
  output logic       ACK,
  output logic       ERR
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] presc;
  logic             tc;
  digit_idx_e       idx, idx_nxt;
  logic [3:0]       sh_h, sh_t, sh_o;
  logic [3:0]       sel_code;
  logic [6:0]       dec_seg;
  logic             blank_lz;

  assign tc = (presc == CNT_LAST);

  always_comb begin
    idx_nxt = idx;
    if (tc) begin
      case (idx)
        IDX_ONES:     idx_nxt = IDX_TENS;
        IDX_TENS:     idx_nxt = IDX_HUNDREDS;
        default:      idx_nxt = IDX_ONES;
      endcase
    end
  end

  always_comb begin
    sel_code = sh_o;
    case (idx)
      IDX_TENS:     sel_code = sh_t;
      IDX_HUNDREDS: sel_code = sh_h;
      default:      sel_code = sh_o;
    endcase
  end

`ifdef LEADING_ZERO_BLANK_EN
  assign blank_lz = ((idx == IDX_HUNDREDS) && (sh_h == 4'd0)) ||
                    ((idx == IDX_TENS) && (sh_h == 4'd0) && (sh_t == 4'd0));
`else
  assign blank_lz = 1'b0;
`endif

  seg7_decode u_dec (
    .code (sel_code),
    .seg  (dec_seg)
  );

  // Capture handshake: LOAD is a per-cycle strobe with no back-pressure; every
  // cycle LOAD=1 at an edge captures the inputs and ACK is 1 for the following cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      presc <= '0;
      idx   <= IDX_ONES;
      sh_h  <= 4'd0;
      sh_t  <= 4'd0;
      sh_o  <= 4'd0;
      SEG   <= SEG_BLANK;
      AN    <= AN_OFF;
      ACK   <= 1'b0;
      ERR   <= 1'b0;
    end else begin
      presc <= tc ? '0 : presc + CNT_W'(1);
      idx   <= idx_nxt;
      ACK   <= LOAD;
      if (LOAD) begin
        sh_h <= HUNDREDS;
        sh_t <= TENS;
        sh_o <= ONES;
        ERR  <= (HUNDREDS > 4'd9) || (TENS > 4'd9) || (ONES > 4'd9);
      end
      // Blank for one cycle whenever the index moves so the old pattern never
      // appears on the new anode.
      if (tc || blank_lz) begin
        SEG <= SEG_BLANK;
        AN  <= AN_OFF;
      end else begin
        SEG <= dec_seg;
        AN  <= an_code(idx);
      end
    end
  end

endmodule

// File: tb/tb_bcd_7seg_scan.sv
// Directed bench for bcd_7seg_scan with REFRESH_DIV=4: vector table plus corner sequences.
module tb_bcd_7seg_scan;

  localparam int DIV = 4;
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] ZB = 7'h7F;
`else
  localparam logic [6:0] ZB = 7'h40;
`endif

  typedef struct {
    logic [3:0] h, t, o;
    logic       e;
    logic [6:0] s_o, s_t, s_h;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst, load;
  logic [3:0] hund, tens, ones;
  logic [6:0] seg;
  logic [2:0] an;
  logic       ack, err;

  int n_cmp = 0;
  int n_bad = 0;
  int k = 0;
  logic [6:0] cur_seg [3];
  vec_t vecs [8];

  bcd_7seg_scan #(.REFRESH_DIV(DIV)) dut (
    .CLK      (clk),
    .RST      (rst),
    .LOAD     (load),
    .HUNDREDS (hund),
    .TENS     (tens),
    .ONES     (ones),
    .SEG      (seg),
    .AN       (an),
    .ACK      (ack),
    .ERR      (err)
  );

  always #5 clk = ~clk;

  // Edges since the last reset edge; the scan position follows from this alone.
  always @(posedge clk) begin
    if (rst) k <= 0;
    else     k <= k + 1;
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (k=%0d)", name, act, exp, k);
    end
  endtask

  function automatic logic [2:0] an_of(input int d);
    case (d)
      0:       return 3'b110;
      1:       return 3'b101;
      default: return 3'b011;
    endcase
  endfunction

  task automatic set_exp(input logic [6:0] so, input logic [6:0] st, input logic [6:0] sh);
    cur_seg[0] = so;
    cur_seg[1] = st;
    cur_seg[2] = sh;
  endtask

  // After edge k (k>=1): blank when k%DIV==0, else digit ((k-1)/DIV)%3.
  task automatic scan_chk(input int n, input logic e);
    int d;
    logic [6:0] es;
    logic [2:0] ea;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      d = ((k - 1) / DIV) % 3;
      if (k % DIV == 0) begin
        es = 7'h7F;
        ea = 3'b111;
      end else begin
        es = cur_seg[d];
        ea = (es == 7'h7F) ? 3'b111 : an_of(d);
      end
      chk("scan_an", {5'd0, an}, {5'd0, ea});
      chk("scan_seg", {1'b0, seg}, {1'b0, es});
      chk("scan_ack", {7'd0, ack}, 8'd0);
      chk("scan_err", {7'd0, err}, {7'd0, e});
    end
  endtask

  task automatic do_load(input vec_t v);
    load = 1'b1;
    hund = v.h;
    tens = v.t;
    ones = v.o;
    @(negedge clk);
    chk("load_ack", {7'd0, ack}, 8'd1);
    chk("load_err", {7'd0, err}, {7'd0, v.e});
    load = 1'b0;
    hund = 4'($urandom_range(0, 15));
    tens = 4'($urandom_range(0, 15));
    ones = 4'($urandom_range(0, 15));
    set_exp(v.s_o, v.s_t, v.s_h);
    scan_chk(12, v.e);
  endtask

  task automatic wait_phase(input int ph);
    int cnt;
    cnt = 0;
    while ((k % 12 != ph) && (cnt < 30)) begin
      @(negedge clk);
      cnt++;
    end
    if (cnt >= 30) begin
      n_cmp++;
      n_bad++;
      $display("FAIL align: phase %0d not reached (k=%0d)", ph, k);
    end
  endtask

  initial begin
    vec_t v;
    vecs[0] = '{4'h2, 4'h5, 4'h5, 1'b0, 7'h12, 7'h12, 7'h24};
    vecs[1] = '{4'h1, 4'hC, 4'h3, 1'b1, 7'h30, 7'h3F, 7'h79};
    vecs[2] = '{4'h1, 4'h2, 4'h3, 1'b0, 7'h30, 7'h24, 7'h79};
    vecs[3] = '{4'h0, 4'h0, 4'h7, 1'b0, 7'h78, ZB,    ZB};
    vecs[4] = '{4'h8, 4'h6, 4'h4, 1'b0, 7'h19, 7'h02, 7'h00};
    vecs[5] = '{4'hF, 4'hA, 4'h0, 1'b1, 7'h40, 7'h3F, 7'h3F};
    vecs[6] = '{4'h0, 4'h9, 4'h0, 1'b0, 7'h40, 7'h10, ZB};
    vecs[7] = '{4'h0, 4'h0, 4'h0, 1'b0, 7'h40, ZB,    ZB};

    // Reset held for two edges; outputs idle throughout.
    rst = 1'b1;
    load = 1'b0;
    hund = 4'h0;
    tens = 4'h0;
    ones = 4'h0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_seg", {1'b0, seg}, 8'h7F);
      chk("rst_an", {5'd0, an}, 8'h07);
      chk("rst_ack", {7'd0, ack}, 8'd0);
      chk("rst_err", {7'd0, err}, 8'd0);
    end
    rst = 1'b0;
    set_exp(7'h40, ZB, ZB);
    scan_chk(12, 1'b0);

    for (int i = 0; i < 8; i++) do_load(vecs[i]);

    // LOAD held three cycles: three captures, three ACKs, last value wins.
    load = 1'b1;
    {hund, tens, ones} = 12'h111;
    @(negedge clk);
    chk("hold_ack1", {7'd0, ack}, 8'd1);
    {hund, tens, ones} = 12'h222;
    @(negedge clk);
    chk("hold_ack2", {7'd0, ack}, 8'd1);
    {hund, tens, ones} = 12'h333;
    @(negedge clk);
    chk("hold_ack3", {7'd0, ack}, 8'd1);
    load = 1'b0;
    {hund, tens, ones} = 12'h888;
    set_exp(7'h30, 7'h30, 7'h30);
    scan_chk(12, 1'b0);

    // Capture on the TENS->HUNDREDS advance edge: new value right after the blank.
    wait_phase(7);
    load = 1'b1;
    {hund, tens, ones} = 12'h999;
    @(negedge clk);
    chk("tc_load_ack", {7'd0, ack}, 8'd1);
    chk("tc_blank_an", {5'd0, an}, 8'h07);
    chk("tc_blank_seg", {1'b0, seg}, 8'h7F);
    load = 1'b0;
    {hund, tens, ones} = 12'h444;
    @(negedge clk);
    chk("tc_hund_an", {5'd0, an}, 8'h03);
    chk("tc_hund_seg", {1'b0, seg}, 8'h10);
    set_exp(7'h10, 7'h10, 7'h10);
    scan_chk(12, 1'b0);

    v = '{4'hF, 4'hF, 4'hF, 1'b1, 7'h3F, 7'h3F, 7'h3F};
    do_load(v);

    // Reset while HUNDREDS is lit, with a competing LOAD that must lose.
    wait_phase(10);
    chk("pre_rst_an", {5'd0, an}, 8'h03);
    rst = 1'b1;
    load = 1'b1;
    {hund, tens, ones} = 12'h555;
    @(negedge clk);
    chk("mid_rst_seg", {1'b0, seg}, 8'h7F);
    chk("mid_rst_an", {5'd0, an}, 8'h07);
    chk("mid_rst_ack", {7'd0, ack}, 8'd0);
    chk("mid_rst_err", {7'd0, err}, 8'd0);
    rst = 1'b0;
    load = 1'b0;
    set_exp(7'h40, ZB, ZB);
    scan_chk(12, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
